// File: rtl/mult_cell_arbiter.sv
// Two-requester arbiter in front of a shared 3-product 16x16 multiplier cell.
// It issues operands to the cell, tracks ops in flight and rebuilds the low 32 bits of a*b.
module mult_cell_arbiter #(
  parameter int LATENCY = 1,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] mc_src1,
  output logic [31:0] mc_src2,
  output logic        mc_en,
  input  logic [31:0] mc_p1,
  input  logic [31:0] mc_p2,
  input  logic [31:0] mc_p3,
  output logic        idle
);

  // Bit k of each pipe describes the op in cell stage k+1.
  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] id_pipe;

  logic [1:0]  slot_valid;
  logic [31:0] slot_data [2];
  logic        rr_ptr;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  inflight;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        accept;
  logic        mid_busy;
  logic        done;
  logic        done_id;
  logic [31:0] cross_sum;
  logic [31:0] res;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    inflight = 2'b00;
    mid_busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      if (vld_pipe[k]) inflight[id_pipe[k]] = 1'b1;
    end
    for (int k = 0; k < LATENCY - 1; k++) begin
      mid_busy = mid_busy | vld_pipe[k];
    end
  end

  assign elig = req_valid & ~slot_valid & ~inflight;

  // rr_ptr holds the last granted requester; on a tie the other one wins.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = (RR_EN && !rr_ptr) ? 2'b10 : 2'b01;
    end
  end

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    mc_src1 = 32'h0;
    mc_src2 = 32'h0;
    if (grant[1]) begin
      mc_src1 = req1_a;
      mc_src2 = req1_b;
    end else if (grant[0]) begin
      mc_src1 = req0_a;
      mc_src2 = req0_b;
    end
  end

  assign mc_en = accept | mid_busy;

  assign done    = vld_pipe[LATENCY-1];
  assign done_id = id_pipe[LATENCY-1];

  // Shifting the full sum left by 16 drops the cross-product bits above bit 15.
  assign cross_sum = mc_p2 + mc_p3;
  assign res       = mc_p1 + (cross_sum << 16);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else if (mc_en) begin
      vld_pipe[0] <= accept;
      id_pipe[0]  <= grant[1];
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end else begin
      vld_pipe[LATENCY-1] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b1;
    end else if (accept) begin
      rr_ptr <= grant[1];
    end
  end

  // A slot cannot be written and consumed together: it is empty while its op is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= 2'b00;
      for (int i = 0; i < 2; i++) slot_data[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (done && (32'(done_id) == i)) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= res;
        end else if (slot_valid[i] && rsp_ready[i]) begin
          slot_valid[i] <= 1'b0;
          slot_data[i]  <= 32'h0;
        end
      end
    end
  end

  assign rsp0_valid = slot_valid[0];
  assign rsp1_valid = slot_valid[1];
  assign rsp0_data  = slot_data[0];
  assign rsp1_data  = slot_data[1];

  assign idle = ~|vld_pipe & ~slot_valid[0] & ~slot_valid[1];

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Drives two arbiter instances (LATENCY=1 round-robin, LATENCY=3 fixed priority) from shared
// stimulus and compares them every cycle with a transaction-level model of requests and slots.
module tb_mult_cell_arbiter;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic [ND-1:0] req0_ready_w, req1_ready_w, rsp0_valid_w, rsp1_valid_w, mc_en_w, idle_w;
  logic [31:0]   rsp0_data_w [ND];
  logic [31:0]   rsp1_data_w [ND];
  logic [31:0]   src1_w [ND];
  logic [31:0]   src2_w [ND];
  logic [31:0]   p1_w [ND];
  logic [31:0]   p2_w [ND];
  logic [31:0]   p3_w [ND];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L  = (g == 0) ? 1 : 3;
    localparam bit RR = (g == 0);
    logic [31:0] sa [L];
    logic [31:0] sb [L];

    // Multiplier cell: L enabled register stages, products formed from the last one.
    always @(posedge clk) begin
      if (mc_en_w[g]) begin
        sa[0] <= src1_w[g];
        sb[0] <= src2_w[g];
        for (int k = 1; k < L; k++) begin
          sa[k] <= sa[k-1];
          sb[k] <= sb[k-1];
        end
      end
    end
    assign p1_w[g] = {16'h0, sa[L-1][15:0]}  * {16'h0, sb[L-1][15:0]};
    assign p2_w[g] = {16'h0, sa[L-1][15:0]}  * {16'h0, sb[L-1][31:16]};
    assign p3_w[g] = {16'h0, sa[L-1][31:16]} * {16'h0, sb[L-1][15:0]};

    mult_cell_arbiter #(.LATENCY(L), .RR_EN(RR)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready_w[g]),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .rsp0_valid (rsp0_valid_w[g]),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data_w[g]),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready_w[g]),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp1_valid (rsp1_valid_w[g]),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data_w[g]),
      .mc_src1    (src1_w[g]),
      .mc_src2    (src2_w[g]),
      .mc_en      (mc_en_w[g]),
      .mc_p1      (p1_w[g]),
      .mc_p2      (p2_w[g]),
      .mc_p3      (p3_w[g]),
      .idle       (idle_w[g])
    );
  end

  // Reference model per instance and requester: 0 = free, 1 = op pending, 2 = result in slot.
  int          st    [ND][2];
  int          due   [ND][2];
  int          issue [ND][2];
  logic [31:0] val   [ND][2];
  logic        last  [ND];
  int          cyc = 0;
  int          ops_d1 = 0;

  always @(negedge clk) begin : model
    logic [1:0]  rv, rr, el, g;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        exp_en, exp_idle;
    rv = {req1_valid, req0_valid};
    rr = {rsp1_ready, rsp0_ready};
    a[0] = req0_a; a[1] = req1_a;
    b[0] = req0_b; b[1] = req1_b;
    for (int d = 0; d < ND; d++) begin
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) st[d][i] = 0;
        last[d] = 1'b1;
        check($sformatf("d%0d_rst_rsp_valid", d), {30'h0, rsp1_valid_w[d], rsp0_valid_w[d]}, 32'h0);
        check($sformatf("d%0d_rst_rsp0_data", d), rsp0_data_w[d], 32'h0);
        check($sformatf("d%0d_rst_rsp1_data", d), rsp1_data_w[d], 32'h0);
        check($sformatf("d%0d_rst_mc_en", d), {31'h0, mc_en_w[d]}, 32'h0);
        check($sformatf("d%0d_rst_idle", d), {31'h0, idle_w[d]}, 32'h1);
      end else begin
        for (int i = 0; i < 2; i++) el[i] = rv[i] && (st[d][i] == 0);
        if (el == 2'b11) g = (d == 0 && last[d] == 1'b0) ? 2'b10 : 2'b01;
        else             g = el;
        exp_en   = |g;
        exp_idle = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (st[d][i] == 1 && cyc - issue[d][i] >= 1 && cyc - issue[d][i] <= lat_of(d) - 1)
            exp_en = 1'b1;
          if (st[d][i] != 0) exp_idle = 1'b0;
        end
        check($sformatf("d%0d_req0_ready", d), {31'h0, req0_ready_w[d]}, {31'h0, g[0]});
        check($sformatf("d%0d_req1_ready", d), {31'h0, req1_ready_w[d]}, {31'h0, g[1]});
        check($sformatf("d%0d_rsp0_valid", d), {31'h0, rsp0_valid_w[d]}, (st[d][0] == 2) ? 32'h1 : 32'h0);
        check($sformatf("d%0d_rsp1_valid", d), {31'h0, rsp1_valid_w[d]}, (st[d][1] == 2) ? 32'h1 : 32'h0);
        check($sformatf("d%0d_rsp0_data", d), rsp0_data_w[d], (st[d][0] == 2) ? val[d][0] : 32'h0);
        check($sformatf("d%0d_rsp1_data", d), rsp1_data_w[d], (st[d][1] == 2) ? val[d][1] : 32'h0);
        check($sformatf("d%0d_mc_en", d), {31'h0, mc_en_w[d]}, {31'h0, exp_en});
        check($sformatf("d%0d_idle", d), {31'h0, idle_w[d]}, {31'h0, exp_idle});
        check($sformatf("d%0d_mc_src1", d), src1_w[d], g[1] ? a[1] : (g[0] ? a[0] : 32'h0));
        check($sformatf("d%0d_mc_src2", d), src2_w[d], g[1] ? b[1] : (g[0] ? b[0] : 32'h0));
        for (int i = 0; i < 2; i++) begin
          if (st[d][i] == 2 && rr[i]) st[d][i] = 0;
          else if (st[d][i] == 1 && due[d][i] == cyc + 1) st[d][i] = 2;
          if (g[i]) begin
            st[d][i]    = 1;
            issue[d][i] = cyc;
            due[d][i]   = cyc + lat_of(d) + 1;
            val[d][i]   = a[i] * b[i];
            last[d]     = (i == 1);
            if (d == 1) ops_d1++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
    step();
    req0_valid = 1'b1; req0_a = a; req0_b = b;
    @(negedge clk);
    check({tag, "_ready"}, {31'h0, req0_ready_w[0]}, 32'h1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, {31'h0, rsp0_valid_w[0]}, 32'h0);
    step();
    @(negedge clk);
    check({tag, "_valid"}, {31'h0, rsp0_valid_w[0]}, 32'h1);
    check({tag, "_data"}, rsp0_data_w[0], exp);
    repeat (4) step();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0001_0000;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    single_op0(32'h0001_2345, 32'h0000_0010, 32'h0012_3450, "basic");
    single_op0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "all_ones");
    single_op0(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "overflow");

    // Both requesters saturating, responses taken at once.
    for (int c = 0; c < 40; c++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = rand_operand(); req0_b = rand_operand();
      req1_a = rand_operand(); req1_b = rand_operand();
    end

    // Requester 0 backpressured while requester 1 keeps working.
    step();
    rsp0_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      req0_a = $urandom; req1_a = $urandom;
    end
    rsp0_ready = 1'b1;
    repeat (6) step();

    // Reset one cycle after an accept on a quiet pipe.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) step();
    req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h5678;
    step();
    req0_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rst_tie_req0", {31'h0, req0_ready_w[0]}, 32'h1);
    check("rst_tie_req1", {31'h0, req1_ready_w[0]}, 32'h0);

    // Random traffic with random backpressure and operand changes while waiting.
    for (int c = 0; c < 1500; c++) begin
      step();
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      req0_a = rand_operand(); req0_b = rand_operand();
      req1_a = rand_operand(); req1_b = rand_operand();
    end

    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("drain_idle", {30'h0, idle_w}, 32'h3);
    check("ops_d1_enough", (ops_d1 >= 200) ? 32'h1 : 32'h0, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
